sub_pipe: RTL
=============

Name: sub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; successor to the combinational subtractor.
- Adds selectable operation, signed/unsigned mode, overflow detection, optional saturation, and a valid/ready handshake with backpressure.
- Sits between datapath registers in the scheduled HLSM datapath wherever a multi-cycle, flow-controlled arithmetic stage is needed.

Parameters:
DATAWIDTH, 16, operand and result width in bits (2..64)
STAGES, 2, pipeline depth in register stages, and therefore latency in cycles (1..4)
SATURATE, 1, 1 = clamp result on overflow; 0 = wrap modulo 2^DATAWIDTH

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous active-low reset (0 = reset)
InValid  input  1  input beat present
InReady  output  1  unit accepts beat this cycle
A  input  DATAWIDTH  operand A
B  input  DATAWIDTH  operand B
Op  input  2  00 A-B, 01 B-A, 10 A+B, 11 |A-B|
Signed  input  1  1 = two's-complement operands, 0 = unsigned
OutValid  output  1  result beat present
OutReady  input  1  downstream accepts beat
Diff  output  DATAWIDTH  result
Ovf  output  1  overflow/borrow/carry occurred for this beat

Behaviour:
- Reset (Rst=0, asynchronous): all stage valid bits = 0, Diff = 0, Ovf = 0, OutValid = 0. Any in-flight data is discarded. InReady = 1 once Rst=1.
- Global advance: Adv = !OutValid | OutReady. InReady = Adv (combinational).
- On every Clk edge with Adv=1, all stages shift one position. Stage 1 captures InValid together with its computed result. With Adv=0, every stage holds.
- Bubbles are not compressed while stalled.
- Accepted beat: InValid & InReady. Results emerge in order exactly STAGES cycles after acceptance when there is no stall.
- A, B, Op and Signed are sampled only on an accepted beat. Values present when InValid=0 never reach the output as valid data.
- Arithmetic is performed in stage 1 on a (DATAWIDTH+1)-bit extended operand (zero- or sign-extended per Signed). The remaining stages are delay registers.
- Unsigned mode:
  - A-B / B-A: Ovf = borrow (minuend < subtrahend). Saturated value = 0.
  - A+B: Ovf = carry out. Saturated value = all ones.
- Signed mode:
  - Ovf = true result outside [-2^(W-1), 2^(W-1)-1].
  - Saturated value = max positive if true result > max, min negative if < min.
- Op=11 |A-B|:
  - Result is the unsigned magnitude of the true difference, which always fits W bits.
  - Ovf = 0 and no saturation, regardless of Signed.
- SATURATE=0: Diff = low W bits of the true result. Ovf is still reported.
- Ovf travels with its beat. Diff and Ovf are meaningful only when OutValid=1. They must hold stable while OutValid=1 & OutReady=0.
- Simultaneous output drain and input accept in the same cycle are legal: full throughput, 1 beat/cycle.
- STAGES=1: the output register is stage 1; latency is 1.

Test Plan:
- W=8, STAGES=2, SAT=1: reset mid-stream with 2 beats in flight. Required: OutValid=0, Diff=0, Ovf=0 immediately while Rst=0; no stale beat emerges after release.
- Unsigned, Op=00, A=5, B=9. Required: Diff=0, Ovf=1 two cycles after accept. Repeat with SAT=0: required Diff=0xFC, Ovf=1.
- Signed, Op=10, A=0x70, B=0x20. Required: Diff=0x7F, Ovf=1. Same inputs with Op=00: required Diff=0x50, Ovf=0. Signed Op=00, A=0x80, B=0x01: required Diff=0x80, Ovf=1.
- Op=11, Signed, A=0x80 (-128), B=0x7F (127). Required: Diff=0xFF, Ovf=0. Op=01, unsigned, A=3, B=10: required Diff=7, Ovf=0.
- Stream of 6 beats with InValid=1 and OutReady=1 every cycle. Required: 6 results in order on consecutive cycles starting at cycle 2 after the first accept.
- Backpressure: OutReady=0 for 3 cycles while the pipe is full. Required: InReady=0, Diff/Ovf held stable, no beat lost or duplicated after OutReady returns to 1.

Source files
------------

// File: rtl/sub_pipe_if.sv
// Handshake and data bundle for the pipelined add/subtract unit.
interface sub_pipe_if #(
  parameter int unsigned DATAWIDTH = 16
);
  logic                 InValid;
  logic                 InReady;
  logic [DATAWIDTH-1:0] A;
  logic [DATAWIDTH-1:0] B;
  logic [1:0]           Op;
  logic                 Signed;
  logic                 OutValid;
  logic                 OutReady;
  logic [DATAWIDTH-1:0] Diff;
  logic                 Ovf;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output InValid, A, B, Op, Signed, OutReady,
    input  InReady, OutValid, Diff, Ovf
  );

  // Arithmetic unit side.
  modport slave (
    input  InValid, A, B, Op, Signed, OutReady,
    output InReady, OutValid, Diff, Ovf
  );
endinterface

// File: rtl/sub_pipe.sv
// Pipelined add/subtract unit with signed/unsigned modes, overflow
// reporting, optional saturation and valid/ready flow control.
// Arithmetic happens in stage 1; later stages only delay the beat.
module sub_pipe #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned SATURATE  = 1
) (
  input logic       Clk,
  input logic       Rst,
  sub_pipe_if.slave bus
);

  localparam int unsigned W = DATAWIDTH;

  logic         adv;
  logic [W:0]   ext_a;
  logic [W:0]   ext_b;
  logic [W:0]   sub_ab;
  logic [W:0]   sub_ba;
  logic [W:0]   sum_ab;
  logic [W:0]   raw;
  logic [W-1:0] sat_val;
  logic         raw_ovf;
  logic [W-1:0] s1_diff;
  logic         s1_ovf;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] ovf_q;
  logic [STAGES-1:0] ovf_d;
  logic [W-1:0]      diff_q [STAGES];
  logic [W-1:0]      diff_d [STAGES];

  // Whole pipe moves together; a held output freezes every stage, so
  // bubbles behind a stalled beat are kept rather than squeezed out.
  assign adv          = !valid_q[STAGES-1] || bus.OutReady;
  assign bus.InReady  = adv;
  assign bus.OutValid = valid_q[STAGES-1];
  assign bus.Diff     = diff_q[STAGES-1];
  assign bus.Ovf      = ovf_q[STAGES-1];

  // Stage-1 arithmetic on W+1 bit operands, then overflow and clamping.
  always_comb begin
    ext_a   = bus.Signed ? {bus.A[W-1], bus.A} : {1'b0, bus.A};
    ext_b   = bus.Signed ? {bus.B[W-1], bus.B} : {1'b0, bus.B};
    sub_ab  = ext_a - ext_b;
    sub_ba  = ext_b - ext_a;
    sum_ab  = ext_a + ext_b;
    raw     = sub_ab;
    raw_ovf = 1'b0;
    sat_val = '0;
    s1_diff = '0;
    s1_ovf  = 1'b0;
    case (bus.Op)
      2'b00:   raw = sub_ab;
      2'b01:   raw = sub_ba;
      2'b10:   raw = sum_ab;
      default: raw = sub_ab[W] ? -sub_ab : sub_ab;
    endcase
    if (bus.Op == 2'b11) begin
      // Magnitude of the difference always fits W bits unsigned.
      s1_diff = raw[W-1:0];
      s1_ovf  = 1'b0;
    end else begin
      if (bus.Signed) begin
        raw_ovf = raw[W] ^ raw[W-1];
        sat_val = {raw[W], {(W-1){~raw[W]}}};
      end else begin
        raw_ovf = raw[W];
        sat_val = (bus.Op == 2'b10) ? '1 : '0;
      end
      s1_ovf  = raw_ovf;
      s1_diff = (raw_ovf && (SATURATE != 0)) ? sat_val : raw[W-1:0];
    end
  end

  // Next-state of the delay line: shift on advance, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    ovf_d   = ovf_q;
    diff_d  = diff_q;
    if (adv) begin
      valid_d[0] = bus.InValid;
      ovf_d[0]   = s1_ovf;
      diff_d[0]  = s1_diff;
      for (int unsigned i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        ovf_d[i]   = ovf_q[i-1];
        diff_d[i]  = diff_q[i-1];
      end
    end
  end

  // Stage registers; reset discards anything in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= '0;
      ovf_q   <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        diff_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      diff_q  <= diff_d;
    end
  end

endmodule
